// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the byte-serial load/store sequencer.
//   SZ_B / SZ_H / SZ_W : request size encodings (2'b11 is illegal)
//   state_t            : sequencer FSM states
//   bytes_of()         : number of RAM beats for a given size
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_H:    n = 3'd2;
      SZ_W:    n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: combinational load-data extension.
//   data   in  32  assembled little-endian load buffer
//   size   in  2   access size (byte / half / word)
//   uns    in  1   1 = zero-extend, 0 = sign-extend
//   rdata  out 32  extended load result
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata
);

  logic fill_b;
  logic fill_h;

  assign fill_b = ~uns & data[7];
  assign fill_h = ~uns & data[15];

  always_comb begin
    rdata = data;
    case (size)
      SZ_B:    rdata = {{24{fill_b}}, data[7:0]};
      SZ_H:    rdata = {{16{fill_h}}, data[15:0]};
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: sequences one 32-bit byte/half/word load or store onto a
// byte-wide RAM slice, one byte per cycle, little-endian.
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we/size/unsigned       store flag, size, zero-extend flag
//   req_addr/req_wdata         byte address, store data
//   rsp_valid/rsp_err/rsp_rdata one-cycle response pulse
//   mem_addr/d/we/sel, mem_q   RAM port (combinational read)
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// XFER  | one RAM byte per cycle, counter i = 0..n-1
// RESP  | rsp_valid pulse (data or error), then back to IDLE
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_d,
  output logic              mem_we,
  output logic              mem_sel,
  input  logic [7:0]        mem_q
);

  state_t              state;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [1:0]          i_q;
  logic [31:0]         rbuf_q;

  logic                illegal;
  logic                last;
  logic                xfer;
  logic [31:0]         ext_rdata;

  // Any address bit above the RAM range makes the request out of range.
  assign illegal = (req_size == 2'b11)
                 | ((req_size == SZ_H) & req_addr[0])
                 | ((req_size == SZ_W) & (|req_addr[1:0]))
                 | (|(req_addr >> ADDR_W));

  assign last = ({1'b0, i_q} == (bytes_of(size_q) - 3'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      i_q     <= 2'd0;
      rbuf_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            err_q   <= illegal;
            i_q     <= 2'd0;
            rbuf_q  <= '0;
            state   <= illegal ? RESP : XFER;
          end
        end
        XFER: begin
          if (!we_q) rbuf_q[{i_q, 3'b000} +: 8] <= mem_q;
          if (last) state <= RESP;
          else      i_q   <= i_q + 2'd1;
        end
        RESP: begin
          i_q   <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lsu_extend u_extend (
    .data  (rbuf_q),
    .size  (size_q),
    .uns   (uns_q),
    .rdata (ext_rdata)
  );

  assign xfer = (state == XFER);

  // rst_n gating keeps the RAM from being written in a cycle held in reset.
  assign mem_sel  = xfer & rst_n;
  assign mem_we   = xfer & we_q & rst_n;
  assign mem_addr = xfer ? (addr_q + ADDR_W'(i_q)) : '0;
  assign mem_d    = xfer ? wdata_q[{i_q, 3'b000} +: 8] : 8'h00;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) & err_q;
  assign rsp_rdata = ((state == RESP) & ~err_q & ~we_q) ? ext_rdata : 32'h0;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed self-checking bench for lsu_byte_seq with a
// behavioural byte RAM (combinational read, write on rising edge).
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_d;
  logic        mem_we;
  logic        mem_sel;
  logic [7:0]  mem_q;

  logic [7:0]  ram [0:1023];

  int checks   = 0;
  int failures = 0;

  int          r_cyc;
  int          r_we;
  int          r_sel;
  logic        r_err;
  logic [31:0] r_rdata;

  always #5 clk = ~clk;

  lsu_byte_seq #(.ADDR_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_d        (mem_d),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_q        (mem_q)
  );

  initial for (int k = 0; k < 1024; k++) ram[k] = 8'h00;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_d;
  assign mem_q = ram[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE; cycle 1 is the cycle after the accept edge.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    tick();
    req_valid = 1'b0;
    r_cyc   = -1;
    r_we    = 0;
    r_sel   = 0;
    r_err   = 1'bx;
    r_rdata = 32'hx;
    for (int c = 1; c <= 10; c++) begin
      if (mem_we)  r_we++;
      if (mem_sel) r_sel++;
      if (rsp_valid) begin
        r_cyc   = c;
        r_err   = rsp_err;
        r_rdata = rsp_rdata;
        tick();
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nrsp;
    int          c1, c2;
    logic [31:0] d1, d2;
    logic        rdy3, rdy4;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    tick();
    tick();

    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp", {29'h0, rsp_valid, rsp_err, |rsp_rdata}, 32'h0);
    chk("rst_mem", {12'h0, mem_sel, mem_we, mem_addr, mem_d}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_mem", {12'h0, mem_sel, mem_we, mem_addr, mem_d}, 32'h0);

    // store word 0xDEADBEEF at 0x010
    run_req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
    chk("sw_cyc", r_cyc, 5);
    chk("sw_err", {31'h0, r_err}, 32'h0);
    chk("sw_rdata", r_rdata, 32'h0);
    chk("sw_we_cycles", r_we, 4);
    chk("sw_ram", {ram[10'h013], ram[10'h012], ram[10'h011], ram[10'h010]}, 32'hDEADBEEF);
    chk("sw_ready_after", {31'h0, req_ready}, 32'h1);

    run_req(1'b0, 2'b00, 1'b0, 32'h013, 32'h0);
    chk("lb_cyc", r_cyc, 2);
    chk("lb_rdata", r_rdata, 32'hFFFFFFDE);
    chk("lb_we", r_we, 0);

    run_req(1'b0, 2'b00, 1'b1, 32'h013, 32'h0);
    chk("lbu_cyc", r_cyc, 2);
    chk("lbu_rdata", r_rdata, 32'h000000DE);

    run_req(1'b0, 2'b01, 1'b0, 32'h012, 32'h0);
    chk("lh_cyc", r_cyc, 3);
    chk("lh_rdata", r_rdata, 32'hFFFFDEAD);

    run_req(1'b0, 2'b01, 1'b1, 32'h010, 32'h0);
    chk("lhu_rdata", r_rdata, 32'h0000BEEF);

    run_req(1'b0, 2'b01, 1'b0, 32'h010, 32'h0);
    chk("lh_low_rdata", r_rdata, 32'hFFFFBEEF);

    run_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    chk("lw_cyc", r_cyc, 5);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw_sel_cycles", r_sel, 4);

    // misaligned half
    run_req(1'b0, 2'b01, 1'b0, 32'h011, 32'h0);
    chk("mis_cyc", r_cyc, 1);
    chk("mis_err", {31'h0, r_err}, 32'h1);
    chk("mis_sel", r_sel, 0);
    chk("mis_rdata", r_rdata, 32'h0);
    chk("mis_ready_after", {31'h0, req_ready}, 32'h1);

    // out of range word
    run_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    chk("oor_err", {31'h0, r_err}, 32'h1);
    chk("oor_rdata", r_rdata, 32'h0);
    chk("oor_sel", r_sel, 0);

    // illegal size store
    run_req(1'b1, 2'b11, 1'b0, 32'h000, 32'hFFFFFFFF);
    chk("sz11_err", {31'h0, r_err}, 32'h1);
    chk("sz11_we", r_we, 0);
    chk("sz11_ram0", {24'h0, ram[10'h000]}, 32'h0);

    // misaligned word, in-range
    run_req(1'b0, 2'b10, 1'b0, 32'h012, 32'h0);
    chk("misw_err", {31'h0, r_err}, 32'h1);

    // store word with reset during XFER cycle 2
    req_we       = 1'b1;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h020;
    req_wdata    = 32'h11223344;
    req_valid    = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_we_gated", {31'h0, mem_we}, 32'h0);
    tick();
    rst_n = 1'b1;
    chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
    nrsp = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) nrsp++;
      tick();
    end
    chk("rstmid_no_rsp", nrsp, 0);
    chk("rstmid_ram", {ram[10'h023], ram[10'h022], ram[10'h021], ram[10'h020]}, 32'h00000044);

    // back-to-back: req_valid held across two byte loads
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b1;
    req_addr     = 32'h010;
    req_valid    = 1'b1;
    tick();
    req_addr = 32'h011;
    nrsp = 0;
    c1 = -1; c2 = -1; d1 = 32'h0; d2 = 32'h0;
    rdy3 = 1'bx; rdy4 = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 1) begin c1 = c; d1 = rsp_rdata; end
        else           begin c2 = c; d2 = rsp_rdata; end
      end
      if (c == 3) rdy3 = req_ready;
      if (c == 4) begin
        rdy4 = req_ready;
        req_valid = 1'b0;
      end
      tick();
    end
    chk("b2b_count", nrsp, 2);
    chk("b2b_c1", c1, 2);
    chk("b2b_c2", c2, 5);
    chk("b2b_d1", d1, 32'h000000EF);
    chk("b2b_d2", d2, 32'h000000BE);
    chk("b2b_ready", {30'h0, rdy3, rdy4}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
